// File: rtl/loop_pkg.sv
// Shared types and defaults for the loop-limit initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package loop_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DONE  = 2'd2,
      ABORT = 2'd3
   } loop_state_t;

   localparam int LOOP_W_DEF    = 16;
   localparam int STOP_HOLD_DEF = 4;

endpackage

// File: rtl/loop_sat_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
// Latency: count reflects inc one cycle later.
// Backpressure: none; inc is a fire-and-forget pulse.
module loop_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   // count events, holding at the maximum value once reached
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/loop_sequencer.sv
// Loop-limit initiator: drives current_loop/stop, aborts on checker fail. Optional stats: LOOP_SEQ_STATS_EN.
// Latency: all outputs registered; start->stop low, step->count, fail->stop high each take 1 cycle.
// Backpressure: none; start is only honoured in IDLE, step/fail/start are ignored while stop is held.
module loop_sequencer
   import loop_pkg::*;
#(
   parameter int LOOP_W    = LOOP_W_DEF,
   parameter int STOP_HOLD = STOP_HOLD_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [LOOP_W-1:0] loop_target,
   input  logic              step,
   input  logic              fail,
   input  logic [LOOP_W-1:0] current_loop_actualize,
   output logic [LOOP_W-1:0] current_loop,
   output logic              stop,
   output logic              busy,
   output logic              done,
   output logic              aborted
`ifdef LOOP_SEQ_STATS_EN
   ,
   output logic [15:0]       run_count,
   output logic [15:0]       abort_count
`endif
);

   localparam int HOLD_W = (STOP_HOLD > 1) ? $clog2(STOP_HOLD) : 1;

   loop_state_t       state_q, state_d;
   logic [LOOP_W-1:0] loop_d;
   logic [LOOP_W-1:0] target_q, target_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [LOOP_W-1:0] loop_inc;
   logic              done_d;
   logic              aborted_d;
   logic              accept;

   assign loop_inc = current_loop + LOOP_W'(1);

   // next-state, counter and pulse decode; fail wins over step in RUN
   always_comb begin
      state_d   = state_q;
      loop_d    = current_loop;
      target_d  = target_q;
      hold_d    = hold_q;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      accept    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               loop_d   = '0;
               target_d = loop_target;
               if (loop_target == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (fail) begin
               loop_d    = current_loop_actualize;
               state_d   = ABORT;
               aborted_d = 1'b1;
            end else if (step) begin
               loop_d = loop_inc;
               if (loop_inc == target_q) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end
         DONE, ABORT: begin
            if (hold_q == HOLD_W'(STOP_HOLD - 1)) begin
               state_d = IDLE;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            hold_d  = '0;
         end
      endcase
   end

   // state and registered outputs; stop/busy are decoded from the next state so they move with it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         current_loop <= '0;
         target_q     <= '0;
         hold_q       <= '0;
         stop         <= 1'b1;
         busy         <= 1'b0;
         done         <= 1'b0;
         aborted      <= 1'b0;
      end else begin
         state_q      <= state_d;
         current_loop <= loop_d;
         target_q     <= target_d;
         hold_q       <= hold_d;
         stop         <= (state_d != RUN);
         busy         <= (state_d == RUN);
         done         <= done_d;
         aborted      <= aborted_d;
      end
   end

`ifdef LOOP_SEQ_STATS_EN
   loop_sat_counter #(.W(16)) u_run_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (accept),
      .count (run_count)
   );

   loop_sat_counter #(.W(16)) u_abort_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (aborted_d),
      .count (abort_count)
   );
`endif

endmodule

// File: tb/tb_loop_sequencer.sv
// Directed bench for loop_sequencer: vector table plus hand sequences for abort, reset and stats.
// Latency: inputs driven 1 time unit after a rising edge, outputs checked 1 unit after the next.
// Backpressure: n/a.
module tb_loop_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] loop_target;
   logic        step;
   logic        fail;
   logic [15:0] current_loop_actualize;
   logic [15:0] current_loop;
   logic        stop;
   logic        busy;
   logic        done;
   logic        aborted;
`ifdef LOOP_SEQ_STATS_EN
   logic [15:0] run_count;
   logic [15:0] abort_count;
`endif

   int vectors;
   int miscompares;

   loop_sequencer #(.LOOP_W(16), .STOP_HOLD(4)) dut (
      .clk                    (clk),
      .reset                  (reset),
      .start                  (start),
      .loop_target            (loop_target),
      .step                   (step),
      .fail                   (fail),
      .current_loop_actualize (current_loop_actualize),
      .current_loop           (current_loop),
      .stop                   (stop),
      .busy                   (busy),
      .done                   (done),
      .aborted                (aborted)
`ifdef LOOP_SEQ_STATS_EN
      ,
      .run_count              (run_count),
      .abort_count            (abort_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        start;
      logic [15:0] tgt;
      logic        step;
      logic        fail;
      logic [15:0] act;
      logic [15:0] e_loop;
      logic        e_stop;
      logic        e_busy;
      logic        e_done;
      logic        e_abort;
   } vec_t;

   vec_t tbl[20];

   function automatic vec_t mk(input logic s, input logic [15:0] t, input logic st,
                               input logic f, input logic [15:0] a, input logic [15:0] el,
                               input logic es, input logic eb, input logic ed, input logic ea);
      vec_t v;
      v.start = s; v.tgt = t; v.step = st; v.fail = f; v.act = a;
      v.e_loop = el; v.e_stop = es; v.e_busy = eb; v.e_done = ed; v.e_abort = ea;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic chk_all(input string nm, input logic [15:0] el, input logic es,
                          input logic eb, input logic ed, input logic ea);
      chk({nm, ".loop"}, 32'(current_loop), 32'(el));
      chk({nm, ".stop"}, 32'(stop), 32'(es));
      chk({nm, ".busy"}, 32'(busy), 32'(eb));
      chk({nm, ".done"}, 32'(done), 32'(ed));
      chk({nm, ".aborted"}, 32'(aborted), 32'(ea));
   endtask

   task automatic drive(input logic s, input logic [15:0] t, input logic st,
                        input logic f, input logic [15:0] a);
      start = s; loop_target = t; step = st; fail = f; current_loop_actualize = a;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_ticks(input int n);
      drive(0, 0, 0, 0, 0);
      for (int k = 0; k < n; k++) begin
         tick();
         chk("hold.stop", 32'(stop), 32'd1);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      drive(0, 0, 0, 0, 0);

      //             start tgt  step fail act  loop stop busy done abort
      tbl[0]  = mk(1, 16'd3, 0, 0, 16'd0,  16'd0, 0, 1, 0, 0);
      tbl[1]  = mk(0, 16'd0, 1, 0, 16'd0,  16'd1, 0, 1, 0, 0);
      tbl[2]  = mk(0, 16'd0, 1, 0, 16'd0,  16'd2, 0, 1, 0, 0);
      tbl[3]  = mk(0, 16'd0, 1, 0, 16'd0,  16'd3, 1, 0, 1, 0);
      tbl[4]  = mk(1, 16'd9, 0, 0, 16'd0,  16'd3, 1, 0, 0, 0);
      tbl[5]  = mk(1, 16'd9, 1, 1, 16'd77, 16'd3, 1, 0, 0, 0);
      tbl[6]  = mk(1, 16'd9, 1, 0, 16'd0,  16'd3, 1, 0, 0, 0);
      tbl[7]  = mk(1, 16'd9, 0, 0, 16'd0,  16'd3, 1, 0, 0, 0);
      tbl[8]  = mk(1, 16'd2, 0, 0, 16'd0,  16'd0, 0, 1, 0, 0);
      tbl[9]  = mk(1, 16'd7, 1, 0, 16'd0,  16'd1, 0, 1, 0, 0);
      tbl[10] = mk(0, 16'd0, 1, 0, 16'd0,  16'd2, 1, 0, 1, 0);
      tbl[11] = mk(0, 16'd0, 0, 0, 16'd0,  16'd2, 1, 0, 0, 0);
      tbl[12] = mk(0, 16'd0, 0, 0, 16'd0,  16'd2, 1, 0, 0, 0);
      tbl[13] = mk(0, 16'd0, 0, 0, 16'd0,  16'd2, 1, 0, 0, 0);
      tbl[14] = mk(0, 16'd0, 0, 0, 16'd0,  16'd2, 1, 0, 0, 0);
      tbl[15] = mk(1, 16'd0, 0, 0, 16'd0,  16'd0, 1, 0, 1, 0);
      tbl[16] = mk(0, 16'd0, 1, 0, 16'd0,  16'd0, 1, 0, 0, 0);
      tbl[17] = mk(0, 16'd0, 0, 1, 16'd55, 16'd0, 1, 0, 0, 0);
      tbl[18] = mk(0, 16'd0, 0, 0, 16'd0,  16'd0, 1, 0, 0, 0);
      tbl[19] = mk(0, 16'd0, 0, 0, 16'd0,  16'd0, 1, 0, 0, 0);

      // reset state
      tick();
      tick();
      chk_all("reset", 16'd0, 1, 0, 0, 0);
      reset = 1'b1;

      // table: target 3 run, hold with ignored inputs, target 2 run, target 0
      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].start, tbl[i].tgt, tbl[i].step, tbl[i].fail, tbl[i].act);
         tick();
         chk_all($sformatf("vec%0d", i), tbl[i].e_loop, tbl[i].e_stop,
                 tbl[i].e_busy, tbl[i].e_done, tbl[i].e_abort);
      end

      // abort after 10 steps; step stays high alongside fail
      drive(1, 16'd5010, 0, 0, 0);
      tick();
      chk_all("ab.start", 16'd0, 0, 1, 0, 0);
      for (int i = 1; i <= 10; i++) begin
         drive(0, 0, 1, 0, 0);
         tick();
         chk("ab.loop", 32'(current_loop), 32'(i));
         chk("ab.done", 32'(done), 32'd0);
      end
      drive(0, 0, 1, 1, 16'd456);
      tick();
      chk_all("ab.fail", 16'd456, 1, 0, 0, 1);
      drive(0, 0, 1, 0, 0);
      tick();
      chk_all("ab.after", 16'd456, 1, 0, 0, 0);
      idle_ticks(3);

      // fail and step together at count 7
      drive(1, 16'd100, 0, 0, 0);
      tick();
      for (int i = 0; i < 7; i++) begin
         drive(0, 0, 1, 0, 0);
         tick();
      end
      chk("fs.loop7", 32'(current_loop), 32'd7);
      drive(0, 0, 1, 1, 16'd8000);
      tick();
      chk_all("fs.fail", 16'd8000, 1, 0, 0, 1);
      idle_ticks(4);

      // asynchronous reset mid-run at count 120
      drive(1, 16'd500, 0, 0, 0);
      tick();
      for (int i = 0; i < 120; i++) begin
         drive(0, 0, 1, 0, 0);
         tick();
      end
      chk_all("rst.pre", 16'd120, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0);
      #2;
      reset = 1'b0;
      #1;
      chk_all("rst.async", 16'd0, 1, 0, 0, 0);
      tick();
      chk_all("rst.held", 16'd0, 1, 0, 0, 0);
      reset = 1'b1;
      drive(1, 16'd2, 0, 0, 0);
      tick();
      chk_all("rst.start", 16'd0, 0, 1, 0, 0);
      drive(0, 0, 1, 0, 0);
      tick();
      chk_all("rst.s1", 16'd1, 0, 1, 0, 0);
      tick();
      chk_all("rst.s2", 16'd2, 1, 0, 1, 0);
      idle_ticks(4);

`ifdef LOOP_SEQ_STATS_EN
      chk("st.run1", 32'(run_count), 32'd1);
      chk("st.abort0", 32'(abort_count), 32'd0);
      // aborted run with a stray start pulse while running
      drive(1, 16'd50, 0, 0, 0);
      tick();
      drive(1, 16'd9, 1, 0, 0);
      tick();
      drive(0, 0, 0, 1, 16'd3);
      tick();
      chk("st.ab", 32'(aborted), 32'd1);
      idle_ticks(4);
      // zero-target run
      drive(1, 16'd0, 0, 0, 0);
      tick();
      idle_ticks(4);
      chk("st.run3", 32'(run_count), 32'd3);
      chk("st.abort1", 32'(abort_count), 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/loop_sequencer.md
Name: loop_sequencer

Overview:
- Initiator side of the loop-limit interface. Generates the `current_loop` iteration count and the `stop` request that the loop-limit checker consumes.
- Reacts to the checker's `fail` flag by loading the clamped `current_loop_actualize` value and aborting the run.
- Sits between the hash-round controller, which supplies `start` and `step` pulses, and the loop-limit checker.

Parameters:
- LOOP_W, 16: width of the loop counter and of all loop-valued ports.
- STOP_HOLD, 4: number of cycles `stop` stays high after a run ends, before returning to IDLE. Minimum 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a run; sampled only in IDLE.
- loop_target  input  LOOP_W  requested iteration count; captured when start is accepted.
- step  input  1  one-cycle pulse per completed hash round.
- fail  input  1  loop-limit checker flag: current_loop exceeded its limit.
- current_loop_actualize  input  LOOP_W  clamped loop value from the checker; valid while fail=1.
- current_loop  output  LOOP_W  registered iteration count driven to the checker.
- stop  output  1  registered; high in DONE and ABORT.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse on the RUN->DONE transition.
- aborted  output  1  one-cycle pulse on the RUN->ABORT transition.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; current_loop=0; stop=1; busy=0; done=0; aborted=0; target register=0; hold counter=0.
- IDLE:
  - stop=1.
  - start=1 with loop_target!=0: capture target, current_loop<=0, stop<=0, go to RUN on the next edge.
  - start=1 with loop_target=0: go directly to DONE, done pulse, current_loop stays 0.
- RUN:
  - step=1: current_loop<=current_loop+1.
  - If the incremented value equals target, the same edge enters DONE, stop<=1, done pulses.
  - fail=1: current_loop<=current_loop_actualize, enter ABORT, stop<=1, aborted pulses.
  - fail has priority over step when both are asserted in the same cycle; no increment occurs.
  - start is ignored in RUN.
  - Increment wraps modulo 2^LOOP_W. Wrap is unreachable in practice because target<2^LOOP_W terminates the run first.
- DONE / ABORT:
  - stop=1; current_loop holds its value.
  - Hold counter counts STOP_HOLD cycles, then the state returns to IDLE; stop stays 1 and current_loop stays held.
  - step, fail and start are ignored during the hold.
- Latency:
  - start to stop=0: 1 cycle.
  - step to current_loop update: 1 cycle.
  - fail to stop=1: 1 cycle.
- Reset asserted mid-run: immediate return to the reset values. No done or aborted pulse is generated.
- Outputs are registered only; there is no combinational path from inputs to outputs.

Optional Feature:
- LOOP_SEQ_STATS_EN defined:
  - Adds outputs run_count (16 bits) and abort_count (16 bits).
  - run_count increments on each accepted start; abort_count increments on each aborted pulse.
  - Both saturate at 16'hFFFF and clear on reset.
- LOOP_SEQ_STATS_EN not defined: the ports and counters are absent, and the remaining behaviour is identical.

Decomposition:
- Shared package loop_pkg:
  - state enum: IDLE, RUN, DONE, ABORT.
  - LOOP_W default.
  - STOP_HOLD default.
- One natural sub-module, loop_sat_counter: a saturating 16-bit counter, instantiated twice when LOOP_SEQ_STATS_EN is defined.
- The FSM and the loop counter stay in the top module.

Test Plan:
- Reset, then start with loop_target=3 and three step pulses:
  - current_loop goes 0,1,2,3.
  - stop drops 1 cycle after start and rises on the edge of the third step.
  - done pulses once.
  - State returns to IDLE 4 cycles later.
- Start with target=5010, step every cycle, fail=1 with current_loop_actualize=456 after 10 steps:
  - current_loop=456 next cycle; stop=1; aborted pulses once; done never pulses.
- fail and step asserted in the same cycle at current_loop=7:
  - current_loop equals current_loop_actualize (e.g. 8000), not 8; ABORT entered.
- Start with loop_target=0:
  - done pulses the next cycle; stop never drops; current_loop=0.
- reset=0 mid-run at current_loop=120:
  - All outputs return immediately to reset values; no done or aborted pulse.
  - After reset=1, start with target=2 completes normally.
- LOOP_SEQ_STATS_EN defined, three runs with one abort:
  - run_count=3, abort_count=1.
  - start pulses during RUN do not increment run_count.
